// File: rtl/lacpu_pkg.sv
// Shared integer-pipeline constants.
//   GR_IDX_W : general-register index width
//   NUM_GR   : number of general registers
//   GR_ZERO  : index of the hardwired-zero register
package lacpu_pkg;

  localparam int GR_IDX_W = 5;
  localparam int NUM_GR = 1 << GR_IDX_W;
  localparam logic [GR_IDX_W-1:0] GR_ZERO = '0;

endpackage

// File: rtl/decoder_n.sv
// Binary-to-one-hot decoder with enable.
//   en     : when low the output is all zeros
//   idx    : binary index, IDX_W bits
//   onehot : 2^IDX_W bit one-hot result
module decoder_n #(
  parameter int IDX_W = 5
) (
  input  logic                    en,
  input  logic [IDX_W-1:0]        idx,
  output logic [(1<<IDX_W)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard for the integer pipeline.
//   clk, resetn : rising-edge clock, asynchronous active-low reset
//   flush       : synchronous clear of every entry (dominates set/clear)
//   set_valid/set_idx : issue marks set_idx busy
//   clr_valid/clr_idx : writeback clears clr_idx
//   rd_idx      : NRD packed source indices, port k at [k*IDX_W +: IDX_W]
//   rd_busy     : per-port pending flag (combinational, clear-bypassed)
//   any_busy    : OR of all entries
//   busy_cnt    : registered popcount of the state
//   busy_vec    : raw state vector
module reg_scoreboard
  import lacpu_pkg::*;
#(
  parameter int IDX_W          = GR_IDX_W,
  parameter int NRD            = 2,
  parameter bit ZERO_HARDWIRED = 1'b1,
  parameter bit CLR_BYPASS     = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    set_valid,
  input  logic [IDX_W-1:0]        set_idx,
  input  logic                    clr_valid,
  input  logic [IDX_W-1:0]        clr_idx,
  input  logic [NRD*IDX_W-1:0]    rd_idx,
  output logic [NRD-1:0]          rd_busy,
  output logic                    any_busy,
  output logic [IDX_W:0]          busy_cnt,
  output logic [(1<<IDX_W)-1:0]   busy_vec
);

  localparam int NUM      = 1 << IDX_W;
  localparam int ZERO_IDX = int'(GR_ZERO);
  localparam logic [NUM-1:0] ONE = {{(NUM-1){1'b0}}, 1'b1};
  // Entries that a set is allowed to touch; the zero register is masked out.
  localparam logic [NUM-1:0] SET_KEEP = ZERO_HARDWIRED ? ~(ONE << ZERO_IDX) : '1;

  logic [NUM-1:0] busy_q;
  logic [NUM-1:0] busy_d;
  logic [NUM-1:0] set_dec;
  logic [NUM-1:0] set_mask;
  logic [NUM-1:0] clr_mask;
  logic [IDX_W:0] cnt_d;

  decoder_n #(.IDX_W(IDX_W)) u_set_dec (
    .en     (set_valid),
    .idx    (set_idx),
    .onehot (set_dec)
  );

  decoder_n #(.IDX_W(IDX_W)) u_clr_dec (
    .en     (clr_valid),
    .idx    (clr_idx),
    .onehot (clr_mask)
  );

  assign set_mask = set_dec & SET_KEEP;

  // Set is OR'ed after the clear so a same-cycle set/clear on one entry
  // leaves it busy: the new producer outlives the retiring one.
  always_comb begin
    busy_d = (busy_q & ~clr_mask) | set_mask;
    if (flush) busy_d = '0;
  end

  // Count is taken from the next state so it always tracks busy_q exactly.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM; i++) begin
      cnt_d = cnt_d + (IDX_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

  // Same-cycle sets are deliberately not forwarded: that would close a
  // combinational loop through the issue stall. Clears may be bypassed.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy[k] = busy_q[rd_idx[k*IDX_W +: IDX_W]] &
                   ~(CLR_BYPASS & clr_mask[rd_idx[k*IDX_W +: IDX_W]]);
    end
  end

  assign any_busy = |busy_q;
  assign busy_vec = busy_q;

endmodule
